// File: rtl/bit_serializer_pkg.sv
// Shared definitions for the bit serializer: FSM state encoding, PRBS-7
// constants and the counter-width helper. The PRBS constants are only used
// when BIT_SERIALIZER_PRBS_EN is defined.
package bit_serializer_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SHIFT = 2'd1,
    ST_PRBS  = 2'd2
  } state_t;

  // PRBS-7, x^7 + x^6 + 1: output is bit 6, feedback is bit 6 xor bit 5
  localparam logic [6:0] PRBS_SEED   = 7'h7F;
  localparam int         PRBS_TAP_HI = 6;
  localparam int         PRBS_TAP_LO = 5;

  // Width of a counter that runs 0..count-1; never narrower than one bit
  function automatic int cnt_width(input int count);
    return (count <= 2) ? 1 : $clog2(count);
  endfunction

endpackage

// File: rtl/bit_serializer_if.sv
// Upstream word handshake for the bit serializer.
// Valid/ready: the master raises s_valid with s_data and holds both stable
// until a rising clk edge sees s_valid & s_ready; that edge transfers the word.
// s_ready never depends combinationally on s_valid.
interface bit_serializer_if #(
  parameter int DATA_W = 8
);
  logic              s_valid;
  logic              s_ready;
  logic [DATA_W-1:0] s_data;

  modport master (output s_valid, output s_data, input s_ready);
  modport slave  (input s_valid, input s_data, output s_ready);
endinterface

// File: rtl/bit_serializer_baud.sv
// Bit-period divider: counts BIT_DIV clocks per serial bit while running.
// tick marks the last clock of a bit, first marks its first clock.
// The count is forced to zero while stopped or when a new word/PRBS run starts.
module bit_serializer_baud
  import bit_serializer_pkg::*;
#(
  parameter int BIT_DIV = 1
) (
  input  logic clk,
  input  logic rst_n,
  input  logic run,
  input  logic restart,
  output logic tick,
  output logic first
);

  localparam int            DW   = cnt_width(BIT_DIV);
  localparam logic [DW-1:0] LAST = DW'(BIT_DIV - 1);

  logic [DW-1:0] cnt_q;

  // Divider counter, wraps to zero at the terminal count
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else if (restart || !run) begin
      cnt_q <= '0;
    end else if (cnt_q == LAST) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_q + DW'(1);
    end
  end

  assign tick  = run && (cnt_q == LAST);
  assign first = run && (cnt_q == '0);

endmodule

// File: rtl/bit_serializer.sv
// Parallel-to-serial feeder for the sequence detector. Words arrive over a
// valid/ready handshake into a one-word hold register, then shift out on
// bit_out, MSB or LSB first. The hold register lets the next word load in the
// same edge the current one ends, so streaming is gap-free.
// Optional feature: define BIT_SERIALIZER_PRBS_EN to add a prbs_mode input
// and a PRBS-7 test-pattern state.
module bit_serializer
  import bit_serializer_pkg::*;
#(
  parameter int   DATA_W   = 8,
  parameter int   BIT_DIV  = 1,
  parameter logic IDLE_LVL = 1'b0
) (
  input  logic                clk,
  input  logic                rst_n,
  bit_serializer_if.slave     s,
  input  logic                lsb_first,
`ifdef BIT_SERIALIZER_PRBS_EN
  input  logic                prbs_mode,
`endif
  output logic                bit_out,
  output logic                bit_strobe,
  output logic                word_done,
  output logic                busy,
  output state_t              dbg_state
);

  localparam int            BW       = cnt_width(DATA_W);
  localparam logic [BW-1:0] LAST_BIT = BW'(DATA_W - 1);

  state_t            state_q, state_d;
  logic [DATA_W-1:0] hold_q;
  logic              hold_full_q;
  logic [DATA_W-1:0] shreg_q;
  logic              lsb_q;
  logic [BW-1:0]     bit_cnt_q;
  logic              ready_int;
  logic              accept;
  logic              load;
  logic              prbs_enter;
  logic              lfsr_step;
  logic              tick;
  logic              first;
  logic              bit_adv;
  logic              last_bit;

  assign ready_int = !hold_full_q && (state_q != ST_PRBS);
  assign s.s_ready = ready_int;
  assign accept    = s.s_valid && ready_int;
  assign bit_adv   = (state_q == ST_SHIFT) && tick;
  assign last_bit  = (bit_cnt_q == LAST_BIT);

  bit_serializer_baud #(.BIT_DIV(BIT_DIV)) u_baud (
    .clk     (clk),
    .rst_n   (rst_n),
    .run     (state_q != ST_IDLE),
    .restart (load || prbs_enter),
    .tick    (tick),
    .first   (first)
  );

  // FSM next state and the per-edge load/advance decisions
  always_comb begin
    state_d    = state_q;
    load       = 1'b0;
    prbs_enter = 1'b0;
    lfsr_step  = 1'b0;
    word_done  = 1'b0;
    case (state_q)
      ST_IDLE: begin
`ifdef BIT_SERIALIZER_PRBS_EN
        if (prbs_mode) begin
          state_d    = ST_PRBS;
          prbs_enter = 1'b1;
        end else
`endif
        if (hold_full_q) begin
          load    = 1'b1;
          state_d = ST_SHIFT;
        end
      end
      ST_SHIFT: begin
        if (tick && last_bit) begin
          word_done = 1'b1;
          if (hold_full_q) begin
            load = 1'b1;
          end else begin
            state_d = ST_IDLE;
          end
        end
      end
`ifdef BIT_SERIALIZER_PRBS_EN
      ST_PRBS: begin
        if (tick) begin
          lfsr_step = 1'b1;
          if (!prbs_mode) begin
            state_d = ST_IDLE;
          end
        end
      end
`endif
      default: state_d = ST_IDLE;
    endcase
  end

  // FSM state register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Hold register: filled on accept, freed on the edge the shifter reads it
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hold_q      <= '0;
      hold_full_q <= 1'b0;
    end else if (accept) begin
      hold_q      <= s.s_data;
      hold_full_q <= 1'b1;
    end else if (load) begin
      hold_full_q <= 1'b0;
    end
  end

  // Shifter and bit counter; bit order is latched with the word
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      shreg_q   <= '0;
      lsb_q     <= 1'b0;
      bit_cnt_q <= '0;
    end else if (load) begin
      shreg_q   <= hold_q;
      lsb_q     <= lsb_first;
      bit_cnt_q <= '0;
    end else if (bit_adv) begin
      shreg_q   <= lsb_q ? (shreg_q >> 1) : (shreg_q << 1);
      bit_cnt_q <= last_bit ? '0 : bit_cnt_q + BW'(1);
    end
  end

`ifdef BIT_SERIALIZER_PRBS_EN
  logic [6:0] lfsr_q;

  // PRBS-7 generator, reseeded on every PRBS entry
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      lfsr_q <= PRBS_SEED;
    end else if (prbs_enter) begin
      lfsr_q <= PRBS_SEED;
    end else if (lfsr_step) begin
      lfsr_q <= {lfsr_q[5:0], lfsr_q[PRBS_TAP_HI] ^ lfsr_q[PRBS_TAP_LO]};
    end
  end
`endif

  // Serial output select: shifter end bit, PRBS bit, or the idle level
  always_comb begin
    bit_out = IDLE_LVL;
    case (state_q)
      ST_SHIFT: bit_out = lsb_q ? shreg_q[0] : shreg_q[DATA_W-1];
`ifdef BIT_SERIALIZER_PRBS_EN
      ST_PRBS:  bit_out = lfsr_q[PRBS_TAP_HI];
`endif
      default:  bit_out = IDLE_LVL;
    endcase
  end

  assign bit_strobe = first;
  assign busy       = (state_q == ST_SHIFT);
  assign dbg_state  = state_q;

endmodule

// File: tb/tb_bit_serializer.sv
// Directed bench for bit_serializer. Two instances share clock and reset:
// dut_a with BIT_DIV=1 and dut_b with BIT_DIV=3. Inputs change 1 time unit
// after a rising edge; outputs are sampled at that same point.
module tb_bit_serializer;
  import bit_serializer_pkg::*;

  logic   clk;
  logic   rst_n;
  int     checks;
  int     failures;

  logic   lsb_a, prbs_a, bit_out_a, strobe_a, done_a, busy_a;
  state_t st_a;
  logic   lsb_b, prbs_b, bit_out_b, strobe_b, done_b, busy_b;
  state_t st_b;

  logic [7:0] src_q[$];
  logic [7:0] exp_q[$];

  bit_serializer_if #(.DATA_W(8)) if_a ();
  bit_serializer_if #(.DATA_W(8)) if_b ();

  bit_serializer #(.DATA_W(8), .BIT_DIV(1), .IDLE_LVL(1'b0)) dut_a (
    .clk        (clk),
    .rst_n      (rst_n),
    .s          (if_a.slave),
    .lsb_first  (lsb_a),
`ifdef BIT_SERIALIZER_PRBS_EN
    .prbs_mode  (prbs_a),
`endif
    .bit_out    (bit_out_a),
    .bit_strobe (strobe_a),
    .word_done  (done_a),
    .busy       (busy_a),
    .dbg_state  (st_a)
  );

  bit_serializer #(.DATA_W(8), .BIT_DIV(3), .IDLE_LVL(1'b0)) dut_b (
    .clk        (clk),
    .rst_n      (rst_n),
    .s          (if_b.slave),
    .lsb_first  (lsb_b),
`ifdef BIT_SERIALIZER_PRBS_EN
    .prbs_mode  (prbs_b),
`endif
    .bit_out    (bit_out_b),
    .bit_strobe (strobe_b),
    .word_done  (done_b),
    .busy       (busy_b),
    .dbg_state  (st_b)
  );

  // Clock
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  // Driver + monitor for dut_a: feeds src_q with s_valid held high, rebuilds
  // words from strobed bits and scores them against exp_q on word_done.
  task automatic run_stream(input int n, input logic lsb, input int budget,
                            output int stalls, output int span);
    int idx = 0;
    int got = 0;
    int bits = 0;
    int cyc_n = 0;
    int first_cyc = -1;
    int last_cyc = 0;
    logic acc;
    logic [7:0] cur = '0;
    stalls = 0;
    lsb_a = lsb;
    while ((idx < n || got < n) && cyc_n < budget) begin
      if (idx < n) begin
        if_a.s_valid = 1'b1;
        if_a.s_data  = src_q[idx];
      end else begin
        if_a.s_valid = 1'b0;
      end
      acc = if_a.s_valid && if_a.s_ready;
      if (if_a.s_valid && !if_a.s_ready) stalls++;
      cyc();
      cyc_n++;
      if (acc) begin
        exp_q.push_back(src_q[idx]);
        idx++;
      end
      if (strobe_a) begin
        bits++;
        if (first_cyc < 0) first_cyc = cyc_n;
        cur = lsb ? {bit_out_a, cur[7:1]} : {cur[6:0], bit_out_a};
      end
      if (done_a) begin
        last_cyc = cyc_n;
        chk("stream_exp_q_nonempty", exp_q.size() > 0, 1);
        if (exp_q.size() > 0) chk($sformatf("stream_word%0d", got), cur, exp_q.pop_front());
        got++;
      end
    end
    if_a.s_valid = 1'b0;
    chk("stream_words", got, n);
    chk("stream_bits", bits, n * 8);
    chk("stream_exp_q_empty", exp_q.size(), 0);
    span = last_cyc - first_cyc + 1;
  endtask

  initial begin
    int stalls, span, done_cnt, ones_cnt, bad;
    logic [7:0] pat;
    logic [6:0] m;
    checks   = 0;
    failures = 0;
    rst_n = 1'b0;
    if_a.s_valid = 1'b0; if_a.s_data = '0; lsb_a = 1'b0; prbs_a = 1'b0;
    if_b.s_valid = 1'b0; if_b.s_data = '0; lsb_b = 1'b0; prbs_b = 1'b0;

    // Reset state
    repeat (3) cyc();
    chk("rst_ready_a", if_a.s_ready, 1);
    chk("rst_bit_a", bit_out_a, 0);
    chk("rst_strobe_a", strobe_a, 0);
    chk("rst_done_a", done_a, 0);
    chk("rst_busy_a", busy_a, 0);
    chk("rst_state_a", st_a, ST_IDLE);
    chk("rst_ready_b", if_b.s_ready, 1);
    chk("rst_busy_b", busy_b, 0);
    rst_n = 1'b1;
    cyc();

    // T1: reset during bit 3 of 8'hFF
    if_a.s_valid = 1'b1; if_a.s_data = 8'hFF; lsb_a = 1'b0;
    cyc();
    if_a.s_valid = 1'b0;
    repeat (4) cyc();
    chk("t1_bit3_pre", bit_out_a, 1);
    chk("t1_busy_pre", busy_a, 1);
    rst_n = 1'b0;
    #1;
    chk("t1_bit_rst", bit_out_a, 0);
    chk("t1_busy_rst", busy_a, 0);
    chk("t1_strobe_rst", strobe_a, 0);
    chk("t1_done_rst", done_a, 0);
    chk("t1_ready_rst", if_a.s_ready, 1);
    chk("t1_state_rst", st_a, ST_IDLE);
    cyc();
    rst_n = 1'b1;
    done_cnt = 0; ones_cnt = 0;
    for (int i = 0; i < 12; i++) begin
      cyc();
      if (done_a) done_cnt++;
      if (bit_out_a) ones_cnt++;
    end
    chk("t1_no_done", done_cnt, 0);
    chk("t1_idle_level", ones_cnt, 0);

    // T2: 8'h99 MSB first, BIT_DIV=1
    pat = 8'h99;
    if_a.s_valid = 1'b1; if_a.s_data = pat; lsb_a = 1'b0;
    cyc();
    chk("t2_ready_low", if_a.s_ready, 0);
    chk("t2_bit_idle", bit_out_a, 0);
    if_a.s_valid = 1'b0;
    for (int i = 0; i < 8; i++) begin
      cyc();
      chk($sformatf("t2_bit%0d", i), bit_out_a, pat[7-i]);
      chk($sformatf("t2_strobe%0d", i), strobe_a, 1);
      chk($sformatf("t2_done%0d", i), done_a, (i == 7));
    end
    cyc();
    chk("t2_end_bit", bit_out_a, 0);
    chk("t2_end_busy", busy_a, 0);
    chk("t2_end_strobe", strobe_a, 0);
    chk("t2_end_done", done_a, 0);

    // T3: 8'hA0 LSB first, BIT_DIV=3 on dut_b
    pat = 8'b1010_0000;
    if_b.s_valid = 1'b1; if_b.s_data = pat; lsb_b = 1'b1;
    cyc();
    if_b.s_valid = 1'b0;
    for (int i = 0; i < 8; i++) begin
      for (int j = 0; j < 3; j++) begin
        cyc();
        chk($sformatf("t3_bit%0d_%0d", i, j), bit_out_b, pat[i]);
        chk($sformatf("t3_strobe%0d_%0d", i, j), strobe_b, (j == 0));
        chk($sformatf("t3_done%0d_%0d", i, j), done_b, (i == 7 && j == 2));
      end
    end
    cyc();
    chk("t3_end_bit", bit_out_b, 0);
    chk("t3_end_busy", busy_b, 0);
    lsb_b = 1'b0;

    // T4: back-to-back 0F, F0, 55 MSB first
    src_q = {8'h0F, 8'hF0, 8'h55};
    run_stream(3, 1'b0, 200, stalls, span);
    chk("t4_stalls", stalls, 8);
    chk("t4_gapfree_span", span, 24);
    cyc();
    chk("t4_end_busy", busy_a, 0);

    // T5: six words LSB first with s_valid held through backpressure
    src_q = {8'h3C, 8'hC3, 8'h81, 8'h7E, 8'h00, 8'hFF};
    run_stream(6, 1'b1, 400, stalls, span);
    chk("t5_stalls", stalls, 29);
    chk("t5_gapfree_span", span, 48);
    cyc();
    chk("t5_end_busy", busy_a, 0);
    chk("t5_end_ready", if_a.s_ready, 1);

`ifdef BIT_SERIALIZER_PRBS_EN
    // T6: PRBS-7 from IDLE, then exit at the next bit boundary
    pat = 8'b1111_1110;
    prbs_a = 1'b1;
    cyc();
    chk("t6_state", st_a, ST_PRBS);
    chk("t6_ready", if_a.s_ready, 0);
    m = 7'h7F;
    bad = 0;
    for (int i = 0; i < 254; i++) begin
      if (i > 0) cyc();
      if (i < 8) chk($sformatf("t6_bit%0d", i), bit_out_a, pat[7-i]);
      if (bit_out_a !== m[6] || strobe_a !== 1'b1 || done_a !== 1'b0) bad++;
      m = {m[5:0], m[6] ^ m[5]};
    end
    chk("t6_seq_bad", bad, 0);
    prbs_a = 1'b0;
    cyc();
    chk("t6_exit_state", st_a, ST_IDLE);
    chk("t6_exit_bit", bit_out_a, 0);
    chk("t6_exit_ready", if_a.s_ready, 1);
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
